dmem_responder: RTL and testbench

- Data-memory responder on the memory side of the xgriscv MEM stage.
- Accepts one load or store request per handshake, with the store byte-lane pattern (amp[3:0]) already computed by the CPU.
- Commits stores per byte lane; aligns and sign-/zero-extends load data.
- Returns a one-cycle response after a fixed latency; the pipeline stalls on req_ready low.

---
 rtl/dmem_if.sv | 34 +++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory request/response bus between the MEM stage and the responder.
// master: CPU side (drives req_*, observes req_ready and rsp_*).
// slave : memory side (observes req_*, drives req_ready and rsp_*).
//   req_valid/req_ready : accept handshake
//   req_we              : 1 store, 0 load
//   req_addr            : byte address
//   req_wdata/req_amp   : lane-positioned store data and byte enables
//   req_lwhb            : load size 01 word, 10 half, 11 byte, 00 word
//   req_unsigned        : zero-extend load
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata/rsp_err   : extended load data, misalignment flag
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_amp;
  logic [1:0]  req_lwhb;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_amp, req_lwhb, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_amp, req_lwhb, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
// One request per handshake; the response strobes LATENCY cycles after accept.
// Stores commit per byte lane and loads are aligned and extended on the edge
// that enters the response cycle.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : dmem_if.slave request/response bus
// Parameters:
//   DEPTH_LOG2 : log2 of memory depth in 32-bit words
//   LATENCY    : accept-to-response cycles, 1..15
// Optional feature macro: DMEM_ALIGN_CHK_EN
//   defined   : misaligned word/half accesses suppress the store, return 0 and
//               raise rsp_err
//   undefined : rsp_err is 0, address low bits only select lanes
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input logic clk,
  input logic reset,
  dmem_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  amp;
    logic [1:0]  lwhb;
    logic        uns;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        rdy, vld, err;
  logic [31:0] rdata;
  req_t        cap, in_req, src;
  logic        accept, commit, mis;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] word, ld;
  logic [3:0][7:0] mem [DEPTH];

  assign in_req = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata,
                    amp: bus.req_amp, lwhb: bus.req_lwhb, uns: bus.req_unsigned};

  assign accept = bus.req_valid && rdy;
  // Edge that enters RESP: end of WAIT, or the accept edge itself when LATENCY==1.
  assign commit = (state == WAIT && cnt == 4'd1) || (accept && LATENCY == 1);
  // The committing request comes from the capture register unless it is being
  // accepted on this very edge.
  assign src    = (state == WAIT) ? cap : in_req;
  assign idx    = src.addr[DEPTH_LOG2+1:2];
  assign word   = mem[idx];

  logic unused_addr;
  assign unused_addr = ^src.addr[31:DEPTH_LOG2+2];

`ifdef DMEM_ALIGN_CHK_EN
  always_comb begin
    mis = 1'b0;
    if (src.we) begin
      if (src.amp == 4'b1111)                          mis = (src.addr[1:0] != 2'b00);
      else if (src.amp == 4'b0011 || src.amp == 4'b1100) mis = src.addr[0];
    end else begin
      if (src.lwhb == 2'b10)      mis = src.addr[0];
      else if (src.lwhb != 2'b11) mis = (src.addr[1:0] != 2'b00);
    end
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{src.addr[1:0], 3'b000} +: 8];
    h = src.addr[1] ? word[31:16] : word[15:0];
    case (src.lwhb)
      2'b11:   ld = src.uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b10:   ld = src.uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: ld = word;
    endcase
    if (src.we || mis) ld = 32'b0;
  end

  // Memory array carries no reset; the reset term keeps a dropped store out.
  always_ff @(posedge clk) begin
    if (commit && !reset && src.we && !mis) begin
      for (int i = 0; i < 4; i++)
        if (src.amp[i]) mem[idx][i] <= src.wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdy   <= 1'b1;
      vld   <= 1'b0;
      rdata <= 32'b0;
      err   <= 1'b0;
      cap   <= '0;
    end else begin
      vld <= 1'b0;
      if (commit) begin
        vld   <= 1'b1;
        rdata <= ld;
        err   <= mis;
      end
      case (state)
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            rdy   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (accept) begin
            cap <= in_req;
            cnt <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state <= RESP;
              rdy   <= 1'b1;
            end else begin
              state <= WAIT;
              rdy   <= 1'b0;
            end
          end else begin
            state <= IDLE;
            rdy   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = rdy;
  assign bus.rsp_valid = vld;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int LAT = 2;
  localparam int DL2 = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus();
  dmem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mm [int];   // reference memory, byte addressed within the wrapped space
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int baddr(input logic [31:0] a);
    return int'(a[DL2+1:0]);
  endfunction

  function automatic int acc_size(input logic we, input logic [3:0] amp, input logic [1:0] lwhb);
    if (we) return (amp == 4'hf) ? 4 : (amp == 4'h3 || amp == 4'hc) ? 2 : 1;
    return (lwhb == 2'b11) ? 1 : (lwhb == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic we, input logic [31:0] a, input logic [3:0] amp,
                                 input logic [1:0] lwhb);
`ifdef DMEM_ALIGN_CHK_EN
    return (baddr(a) % acc_size(we, amp, lwhb)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] lwhb, input logic uns);
    int n = acc_size(1'b0, 4'h0, lwhb);
    int base = baddr(a) / n * n;
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(mm[base + i]) << (8 * i);
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] amp);
    int base = baddr(a) / 4 * 4;
    for (int i = 0; i < 4; i++) if (amp[i]) mm[base + i] = wd[8*i +: 8];
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] amp, input logic [1:0] lwhb, input logic uns);
    bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
    bus.req_amp = amp; bus.req_lwhb = lwhb; bus.req_unsigned = uns;
  endtask

  task automatic scramble();
    drive(1'($urandom), $urandom, $urandom, 4'($urandom), 2'($urandom), 1'($urandom));
  endtask

  // One full transaction, checked against the reference model.
  task automatic op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] amp, input logic [1:0] lwhb, input logic uns,
                    input string tag, output logic [31:0] rdo);
    logic exp_err;
    logic [31:0] exp_rd;
    exp_err = m_mis(we, a, amp, lwhb);
    exp_rd  = (we || exp_err) ? 32'h0 : m_load(a, lwhb, uns);
    if (we && !exp_err) m_store(a, wd, amp);
    rdo = 32'hx;
    @(negedge clk);
    chk({tag, ".idle_vld"}, bus.rsp_valid, 1'b0);
    chk({tag, ".rdy"}, bus.req_ready, 1'b1);
    drive(we, a, wd, amp, lwhb, uns);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    scramble();
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        chk({tag, ".busy"}, {bus.req_ready, bus.rsp_valid}, 2'b00);
      end else begin
        chk({tag, ".vld"}, bus.rsp_valid, 1'b1);
        chk({tag, ".rdata"}, bus.rsp_rdata, exp_rd);
        chk({tag, ".err"}, bus.rsp_err, exp_err);
        rdo = bus.rsp_rdata;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 2'b01, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.vld", bus.rsp_valid, 1'b0);
    chk("rst.rdy", bus.req_ready, 1'b1);
    chk("rst.rdata", bus.rsp_rdata, 32'h0);
    chk("rst.err", bus.rsp_err, 1'b0);
    reset = 1'b0;

    op(1, 32'h10, 32'h11223344, 4'b1111, 2'b00, 0, "sw10", rd);
    op(0, 32'h10, 32'h0, 4'h0, 2'b01, 0, "lw10", rd);
    chk("lw10.c", rd, 32'h11223344);

    op(1, 32'h11, 32'h0000AB00, 4'b0010, 2'b00, 0, "sb11", rd);
    op(0, 32'h11, 32'h0, 4'h0, 2'b11, 0, "lb11", rd);
    chk("lb11.c", rd, 32'hFFFFFFAB);
    op(0, 32'h11, 32'h0, 4'h0, 2'b11, 1, "lbu11", rd);
    chk("lbu11.c", rd, 32'h000000AB);
    op(0, 32'h10, 32'h0, 4'h0, 2'b01, 0, "lw10b", rd);
    chk("lw10b.c", rd, 32'h1122AB44);

    op(1, 32'h12, 32'h80000000, 4'b1100, 2'b00, 0, "sh12", rd);
    op(0, 32'h12, 32'h0, 4'h0, 2'b10, 0, "lh12", rd);
    chk("lh12.c", rd, 32'hFFFF8000);
    op(0, 32'h12, 32'h0, 4'h0, 2'b10, 1, "lhu12", rd);
    chk("lhu12.c", rd, 32'h00008000);
    op(0, 32'h10, 32'h0, 4'h0, 2'b10, 0, "lh10", rd);
    chk("lh10.c", rd, 32'hFFFFAB44);

    op(1, 32'h10, 32'hFFFFFFFF, 4'b0000, 2'b00, 0, "snone", rd);
    op(0, 32'h10, 32'h0, 4'h0, 2'b00, 0, "lw00", rd);
    chk("lw00.c", rd, 32'h8000AB44);

    op(1, 32'h20 + (32'h1 << (DL2 + 2)), 32'h12345678, 4'b1111, 2'b00, 0, "swwrap", rd);
    op(0, 32'h20, 32'h0, 4'h0, 2'b01, 0, "lwwrap", rd);
    chk("lwwrap.c", rd, 32'h12345678);

    // req_valid held high across two loads
    @(negedge clk);
    chk("b2b.idle", bus.rsp_valid, 1'b0);
    drive(0, 32'h10, 32'h0, 4'h0, 2'b01, 0);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 drive(0, 32'h13, 32'h0, 4'h0, 2'b11, 1);
    @(negedge clk);
    chk("b2b.t1", {bus.req_ready, bus.rsp_valid}, 2'b00);
    @(negedge clk);
    chk("b2b.t2vld", bus.rsp_valid, 1'b1);
    chk("b2b.t2rdy", bus.req_ready, 1'b1);
    chk("b2b.t2rd", bus.rsp_rdata, 32'h8000AB44);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b.t3", {bus.req_ready, bus.rsp_valid}, 2'b00);
    @(negedge clk);
    chk("b2b.t4vld", bus.rsp_valid, 1'b1);
    chk("b2b.t4rd", bus.rsp_rdata, 32'h00000080);

    // store accepted, then reset before it can commit
    @(negedge clk);
    drive(1, 32'h10, 32'hDEADBEEF, 4'b1111, 2'b00, 0);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid.vld", bus.rsp_valid, 1'b0);
    chk("rstmid.rdy", bus.req_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid.vld2", bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk("rstmid.vld3", bus.rsp_valid, 1'b0);
    op(0, 32'h10, 32'h0, 4'h0, 2'b01, 0, "rstmid.lw", rd);
    chk("rstmid.lw.c", rd, 32'h8000AB44);

`ifdef DMEM_ALIGN_CHK_EN
    op(0, 32'h12, 32'h0, 4'h0, 2'b01, 0, "mis.lw", rd);
    chk("mis.lw.c", rd, 32'h0);
    op(1, 32'h12, 32'hCAFEF00D, 4'b1111, 2'b00, 0, "mis.sw", rd);
    op(0, 32'h10, 32'h0, 4'h0, 2'b01, 0, "mis.chk", rd);
    chk("mis.chk.c", rd, 32'h8000AB44);
`else
    op(0, 32'h12, 32'h0, 4'h0, 2'b01, 0, "lane.lw", rd);
    chk("lane.lw.c", rd, 32'h8000AB44);
`endif

    // randomized traffic over a small initialised window, with aliases
    for (int w = 0; w < 16; w++)
      op(1, 32'h100 + 32'(4 * w), $urandom, 4'b1111, 2'b00, 0, "rinit", rd);
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 63)) + ((32'($urandom_range(0, 3))) << (DL2 + 2));
      if ($urandom_range(0, 2) == 0)
        op(1, a, $urandom, 4'($urandom), 2'b00, 0, "rst_", rd);
      else
        op(0, a, 32'h0, 4'h0, 2'($urandom), 1'($urandom), "rld", rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
